// File: rtl/stage5_pkg.sv
// Shared types and helpers for DAL score pipeline stage 5.
// sat_add/sext back the signed saturating arithmetic enabled by STAGE5_SAT_EN.
package stage5_pkg;

    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned NINT_DEF = 16;

    typedef logic [DW_DEF-1:0] data_t;

    typedef struct packed {
        data_t idx;
        data_t cnt;
    } best_t;

    // Sign-extend the low w bits of x (w <= 32).
    function automatic longint sext(input logic [31:0] x, input int unsigned w);
        logic signed [31:0] t;
        t = $signed(x << (32 - w));
        return longint'(t >>> (32 - w));
    endfunction

    // Signed add clamped to the w-bit two's-complement range.
    function automatic logic [31:0] sat_add(input longint a, input longint b,
                                            input int unsigned w);
        longint s;
        longint hi;
        longint lo;
        s  = a + b;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/stage5_hist.sv
// Per-interval sample histogram and score accumulator with a sample-index and a mode read port.
// Accumulator saturates (signed) when STAGE5_SAT_EN is defined, otherwise wraps.
module stage5_hist
    import stage5_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NINT = NINT_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [DW-1:0] idx_i,
    input  logic [DW-1:0] acc_s_i,
    input  logic [DW-1:0] mode_idx_i,
    output logic [DW-1:0] hist_rd_o,
    output logic [DW-1:0] acc_rd_at_mode_o
);

    localparam int unsigned IW = (NINT > 1) ? $clog2(NINT) : 1;

    logic [DW-1:0] hist_q [NINT];
    logic [DW-1:0] acc_q  [NINT];

    logic          idx_ok;
    logic          mode_ok;
    logic [IW-1:0] idx_lo;
    logic [IW-1:0] mode_lo;
    logic [DW-1:0] acc_rd;
    logic [DW-1:0] hist_nxt;
    logic [DW-1:0] acc_nxt;

    assign idx_ok  = (idx_i < DW'(NINT));
    assign mode_ok = (mode_idx_i < DW'(NINT));
    assign idx_lo  = idx_i[IW-1:0];
    assign mode_lo = mode_idx_i[IW-1:0];

    assign hist_rd_o        = idx_ok  ? hist_q[idx_lo] : '0;
    assign acc_rd           = idx_ok  ? acc_q[idx_lo]  : '0;
    assign acc_rd_at_mode_o = mode_ok ? acc_q[mode_lo] : '0;

    always_comb begin
        hist_nxt = (hist_rd_o == '1) ? hist_rd_o : hist_rd_o + DW'(1);
`ifdef STAGE5_SAT_EN
        acc_nxt = DW'(sat_add(sext(32'(acc_rd), DW), sext(32'(acc_s_i), DW), DW));
`else
        acc_nxt = acc_rd + acc_s_i;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NINT; i++) begin
                hist_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else if (we_i && idx_ok) begin
            hist_q[idx_lo] <= hist_nxt;
            acc_q[idx_lo]  <= acc_nxt;
        end
    end

endmodule

// File: rtl/pipe_stage_5.sv
// DAL score pipeline stage 5: interval histogram, running mode selection and interpolation
// coefficient registers. Define STAGE5_SAT_EN for signed saturating coefficient/accumulator math.
module pipe_stage_5
    import stage5_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NINT = NINT_DEF
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    input  logic          mode,
    input  logic [DW-1:0] acc_s,
    input  logic [DW-1:0] interval_cnt_i,
    input  logic [DW-1:0] mode_i,
    input  logic [DW-1:0] max_cnt_i,
    input  logic [DW-1:0] a_acc_i,
    input  logic [DW-1:0] a_pos_i,
    input  logic [DW-1:0] b_acc_i,
    input  logic [DW-1:0] b_pos_i,
    input  logic [DW-1:0] J_size,
    output logic [DW-1:0] mode_o,
    output logic [DW-1:0] max_cnt_o,
    output logic [DW-1:0] interval_cnt_o,
    output logic [DW-1:0] acc_interval_o,
    output logic [DW-1:0] alpha_o,
    output logic [DW-1:0] _alpha_o,
    output logic [DW-1:0] beta_o,
    output logic [DW-1:0] U_add,
    output logic          finished
);

    logic [DW-1:0] mode_q, mode_d, max_cnt_q, max_cnt_d, icnt_q, icnt_d;
    logic [DW-1:0] alpha_q, alpha_d, nalpha_q, nalpha_d, beta_q, beta_d, uadd_q, uadd_d;
    logic [DW-1:0] smp_q, smp_d, smp_inc;
    logic          finished_q, finished_d;

    logic          sample;
    logic          idx_ok;
    logic [DW-1:0] hist_rd;
    logic [DW-1:0] hist_inc;
    logic [DW-1:0] cand_idx;
    logic [DW-1:0] cand_cnt;

    // A zero-length sequence never samples; it only raises finished.
    assign sample   = mode && !finished_q && (J_size != '0);
    assign idx_ok   = (interval_cnt_i < DW'(NINT));
    assign smp_inc  = smp_q + DW'(1);
    assign hist_inc = (hist_rd == '1) ? hist_rd : hist_rd + DW'(1);

    stage5_hist #(
        .DW   (DW),
        .NINT (NINT)
    ) u_hist (
        .clk_i            (CLK_i),
        .rst_ni           (RST_i),
        .we_i             (sample),
        .idx_i            (interval_cnt_i),
        .acc_s_i          (acc_s),
        .mode_idx_i       (mode_q),
        .hist_rd_o        (hist_rd),
        .acc_rd_at_mode_o (acc_interval_o)
    );

    always_comb begin
        mode_d     = mode_q;
        max_cnt_d  = max_cnt_q;
        icnt_d     = icnt_q;
        alpha_d    = alpha_q;
        nalpha_d   = nalpha_q;
        beta_d     = beta_q;
        uadd_d     = uadd_q;
        smp_d      = smp_q;
        finished_d = finished_q;
        cand_idx   = mode_q;
        cand_cnt   = max_cnt_q;

        if (!finished_q && (J_size == '0)) begin
            finished_d = 1'b1;
        end

        if (sample) begin
            icnt_d = interval_cnt_i;
            smp_d  = smp_inc;
            if (smp_inc == J_size) begin
                finished_d = 1'b1;
            end

            // Strict greater-than keeps the incumbent on ties.
            if (max_cnt_i > cand_cnt) begin
                cand_idx = mode_i;
                cand_cnt = max_cnt_i;
            end
            if (idx_ok && (hist_inc > cand_cnt)) begin
                cand_idx = interval_cnt_i;
                cand_cnt = hist_inc;
            end
            mode_d    = cand_idx;
            max_cnt_d = cand_cnt;

`ifdef STAGE5_SAT_EN
            alpha_d  = DW'(sat_add(sext(32'(b_acc_i), DW), -sext(32'(a_acc_i), DW), DW));
            nalpha_d = (alpha_d == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}}
                                                           : '0 - alpha_d;
            beta_d   = DW'(sat_add(sext(32'(b_pos_i), DW), -sext(32'(a_pos_i), DW), DW));
            uadd_d   = DW'(sat_add(sext(32'(a_acc_i), DW), sext(32'(b_acc_i), DW), DW));
`else
            alpha_d  = b_acc_i - a_acc_i;
            nalpha_d = a_acc_i - b_acc_i;
            beta_d   = b_pos_i - a_pos_i;
            uadd_d   = a_acc_i + b_acc_i;
`endif
        end
    end

    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            mode_q     <= '0;
            max_cnt_q  <= '0;
            icnt_q     <= '0;
            alpha_q    <= '0;
            nalpha_q   <= '0;
            beta_q     <= '0;
            uadd_q     <= '0;
            smp_q      <= '0;
            finished_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            max_cnt_q  <= max_cnt_d;
            icnt_q     <= icnt_d;
            alpha_q    <= alpha_d;
            nalpha_q   <= nalpha_d;
            beta_q     <= beta_d;
            uadd_q     <= uadd_d;
            smp_q      <= smp_d;
            finished_q <= finished_d;
        end
    end

    assign mode_o         = mode_q;
    assign max_cnt_o      = max_cnt_q;
    assign interval_cnt_o = icnt_q;
    assign alpha_o        = alpha_q;
    assign _alpha_o       = nalpha_q;
    assign beta_o         = beta_q;
    assign U_add          = uadd_q;
    assign finished       = finished_q;

endmodule

// File: tb/tb_pipe_stage_5.sv
// Directed self-checking bench for pipe_stage_5 (expected values follow STAGE5_SAT_EN if defined).
module tb_pipe_stage_5;

    logic        CLK_i = 1'b0;
    logic        RST_i = 1'b0;
    logic        mode  = 1'b0;
    logic [15:0] acc_s = '0, interval_cnt_i = '0, mode_i = '0, max_cnt_i = '0;
    logic [15:0] a_acc_i = '0, a_pos_i = '0, b_acc_i = '0, b_pos_i = '0, J_size = '0;
    logic [15:0] mode_o, max_cnt_o, interval_cnt_o, acc_interval_o;
    logic [15:0] alpha_o, nalpha_o, beta_o, U_add;
    logic        finished;

    int nvec = 0;
    int nmis = 0;

    pipe_stage_5 dut (
        .CLK_i          (CLK_i),
        .RST_i          (RST_i),
        .mode           (mode),
        .acc_s          (acc_s),
        .interval_cnt_i (interval_cnt_i),
        .mode_i         (mode_i),
        .max_cnt_i      (max_cnt_i),
        .a_acc_i        (a_acc_i),
        .a_pos_i        (a_pos_i),
        .b_acc_i        (b_acc_i),
        .b_pos_i        (b_pos_i),
        .J_size         (J_size),
        .mode_o         (mode_o),
        .max_cnt_o      (max_cnt_o),
        .interval_cnt_o (interval_cnt_o),
        .acc_interval_o (acc_interval_o),
        .alpha_o        (alpha_o),
        ._alpha_o       (nalpha_o),
        .beta_o         (beta_o),
        .U_add          (U_add),
        .finished       (finished)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        assert (got === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic samp(input logic [15:0] idx, input logic [15:0] s);
        interval_cnt_i = idx;
        acc_s          = s;
        tick();
    endtask

    // Asserts reset for one edge, applies new J_size, releases just after the edge.
    task automatic restart(input logic [15:0] jsz);
        RST_i = 1'b0;
        #2;
        tick();
        J_size = jsz;
        RST_i  = 1'b1;
    endtask

    initial begin
        // 1: reset state, then idle with mode=0
        J_size = 16'd4;
        tick();
        chk("rst_mode_o", mode_o, 16'h0);
        chk("rst_max_cnt", max_cnt_o, 16'h0);
        chk("rst_icnt", interval_cnt_o, 16'h0);
        chk("rst_acc_int", acc_interval_o, 16'h0);
        chk("rst_alpha", alpha_o, 16'h0);
        chk("rst_nalpha", nalpha_o, 16'h0);
        chk("rst_beta", beta_o, 16'h0);
        chk("rst_uadd", U_add, 16'h0);
        chk("rst_finished", {15'h0, finished}, 16'h0);
        RST_i = 1'b1;
        interval_cnt_i = 16'd3;
        acc_s = 16'd50;
        repeat (5) tick();
        chk("idle_mode_o", mode_o, 16'h0);
        chk("idle_icnt", interval_cnt_o, 16'h0);
        chk("idle_finished", {15'h0, finished}, 16'h0);

        // 2: four samples, mode interval 3
        mode = 1'b1;
        samp(16'd3, 16'd10);
        chk("s1_mode_o", mode_o, 16'd3);
        chk("s1_max_cnt", max_cnt_o, 16'd1);
        chk("s1_acc_int", acc_interval_o, 16'd10);
        samp(16'd3, 16'd10);
        samp(16'd5, 16'd7);
        chk("s3_finished", {15'h0, finished}, 16'h0);
        samp(16'd3, 16'd1);
        chk("s4_mode_o", mode_o, 16'd3);
        chk("s4_max_cnt", max_cnt_o, 16'd3);
        chk("s4_acc_int", acc_interval_o, 16'd21);
        chk("s4_icnt", interval_cnt_o, 16'd3);
        chk("s4_finished", {15'h0, finished}, 16'h1);
        samp(16'd5, 16'd100);
        samp(16'd5, 16'd100);
        chk("post_mode_o", mode_o, 16'd3);
        chk("post_max_cnt", max_cnt_o, 16'd3);
        chk("post_icnt", interval_cnt_o, 16'd3);
        chk("post_acc_int", acc_interval_o, 16'd21);

        // Asynchronous reset mid-state clears everything immediately
        RST_i = 1'b0;
        #1;
        chk("arst_mode_o", mode_o, 16'h0);
        chk("arst_acc_int", acc_interval_o, 16'h0);
        chk("arst_finished", {15'h0, finished}, 16'h0);

        // 3: tie keeps the earlier interval
        restart(16'd2);
        samp(16'd2, 16'd4);
        samp(16'd6, 16'd9);
        chk("tie_mode_o", mode_o, 16'd2);
        chk("tie_max_cnt", max_cnt_o, 16'd1);
        chk("tie_acc_int", acc_interval_o, 16'd4);
        restart(16'd1);
        mode_i = 16'd9;
        max_cnt_i = 16'd5;
        samp(16'd2, 16'd4);
        chk("up_mode_o", mode_o, 16'd9);
        chk("up_max_cnt", max_cnt_o, 16'd5);
        chk("up_acc_int", acc_interval_o, 16'd0);
        mode_i = 16'd0;
        max_cnt_i = 16'd0;

        // 4: coefficients, then pause/resume via mode
        restart(16'd2);
        a_acc_i = 16'd5;
        b_acc_i = 16'd12;
        a_pos_i = 16'd2;
        b_pos_i = 16'd10;
        samp(16'd0, 16'd1);
        chk("c_alpha", alpha_o, 16'd7);
        chk("c_nalpha", nalpha_o, 16'hFFF9);
        chk("c_beta", beta_o, 16'd8);
        chk("c_uadd", U_add, 16'd17);
        chk("c_finished", {15'h0, finished}, 16'h0);
        mode = 1'b0;
        a_acc_i = 16'd1;
        samp(16'd4, 16'd1);
        samp(16'd4, 16'd1);
        chk("pause_alpha", alpha_o, 16'd7);
        chk("pause_icnt", interval_cnt_o, 16'd0);
        chk("pause_finished", {15'h0, finished}, 16'h0);
        mode = 1'b1;
        samp(16'd0, 16'd1);
        chk("resume_alpha", alpha_o, 16'd11);
        chk("resume_max_cnt", max_cnt_o, 16'd2);
        chk("resume_acc_int", acc_interval_o, 16'd2);
        chk("resume_finished", {15'h0, finished}, 16'h1);

        // 5: J_size=0 finishes on first edge without sampling; out-of-range index
        a_acc_i = '0; b_acc_i = '0; a_pos_i = '0; b_pos_i = '0;
        mode = 1'b0;
        restart(16'd0);
        chk("j0_pre_finished", {15'h0, finished}, 16'h0);
        mode = 1'b1;
        samp(16'd1, 16'd3);
        chk("j0_finished", {15'h0, finished}, 16'h1);
        chk("j0_max_cnt", max_cnt_o, 16'h0);
        chk("j0_icnt", interval_cnt_o, 16'h0);
        restart(16'd1);
        samp(16'd20, 16'd50);
        chk("oor_finished", {15'h0, finished}, 16'h1);
        chk("oor_max_cnt", max_cnt_o, 16'h0);
        chk("oor_mode_o", mode_o, 16'h0);
        chk("oor_icnt", interval_cnt_o, 16'd20);

        // 6: overflow behaviour
        restart(16'd2);
        a_acc_i = 16'h7000;
        b_acc_i = 16'h7000;
        samp(16'd1, 16'd0);
`ifdef STAGE5_SAT_EN
        chk("ovf_uadd", U_add, 16'h7FFF);
`else
        chk("ovf_uadd", U_add, 16'hE000);
`endif
        chk("ovf_alpha", alpha_o, 16'h0);
        a_acc_i = 16'h0001;
        b_acc_i = 16'h8000;
        samp(16'd1, 16'd0);
`ifdef STAGE5_SAT_EN
        chk("neg_alpha", alpha_o, 16'h8000);
        chk("neg_nalpha", nalpha_o, 16'h7FFF);
`else
        chk("neg_alpha", alpha_o, 16'h7FFF);
        chk("neg_nalpha", nalpha_o, 16'h8001);
`endif
        chk("neg_uadd", U_add, 16'h8001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
